arbiter: RTL and testbench
==========================

Name: arbiter

Overview:
- Registered round-robin arbiter for NUM_REQ requesters sharing one resource.
- Samples the request vector every clock and drives a one-hot (or all-zero) grant vector one cycle later.
- Rotating priority prevents starvation.
- Sits between request sources (bus masters, queues) and a single shared target. Grant exclusivity ($onehot0) is the key safety property.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..32.
- IDX_W, $clog2(NUM_REQ), width of the encoded grant index (derived; do not override).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset (asserted when 0)
- req  input  NUM_REQ  request vector; bit i = requester i wants the resource
- gnt  output  NUM_REQ  registered grant vector; at most one bit set
- gnt_vld  output  1  registered; 1 when any gnt bit is set (= |gnt)
- gnt_idx  output  IDX_W  registered binary index of the set gnt bit; 0 when gnt_vld=0

Behaviour:
- Reset (rst=0, asynchronous):
  - gnt=0, gnt_vld=0, gnt_idx=0.
  - Priority pointer ptr=0, so requester 0 has highest priority after reset.
  - Outputs clear immediately on rst falling, without waiting for a clock edge.
  - Arbitration resumes on the first rising clk after rst returns to 1.
- Arbitration on each rising clk while rst=1:
  - Search req starting at bit ptr, ascending and wrapping modulo NUM_REQ.
  - The first set bit k wins.
  - Next cycle: gnt=1<<k, gnt_idx=k, gnt_vld=1, and ptr becomes (k+1) mod NUM_REQ.
- No requests (req=0): gnt=0, gnt_vld=0, gnt_idx=0; ptr unchanged.
- Latency: exactly 1 cycle from req sample to gnt. gnt is a pure function of req and ptr sampled at the previous edge.
- Grants are not held or locked:
  - Arbitration is re-run every cycle.
  - A lone continuous requester is granted every cycle, with ptr advancing past it each time.
- Fairness: with all NUM_REQ bits continuously set, grants rotate 0,1,2,…,NUM_REQ-1,0,…
  - Any continuously asserted request is granted within NUM_REQ cycles.
- Invariant: $onehot0(gnt) at every rising clk, including during and immediately after reset.
- Dropped request: if the granted requester drops req, its gnt bit drops on the next edge.
- Wrap-around: ptr=NUM_REQ-1 with req[NUM_REQ-1]=1 grants NUM_REQ-1, then ptr wraps to 0.
- Outputs must be glitch-free flops. No combinational path from req to gnt.
- X on req is not permitted while rst=1; behaviour is undefined in that case.

Decomposition:
- Package arbiter_pkg holds:
  - localparam DEFAULT_NUM_REQ=4.
  - A function onehot_to_idx for the gnt_idx encoding.
  - A function rotl/rotr used by the picker.
- Sub-module rr_picker (combinational):
  - Inputs: req and ptr.
  - Outputs: next one-hot grant and its index.
  - Implementation: rotate req right by ptr, apply a fixed priority-encode (lowest bit wins), then rotate back.
- The top level holds the ptr register, the output registers, and the reset logic.

Test Plan:
- Reset: hold rst=0 with req=4'b1111 for 2 cycles -> gnt=0, gnt_vld=0, gnt_idx=0 throughout. Then release rst -> first grant is gnt=4'b0001.
- Full load rotation: req=4'b1111 for 8 cycles after reset -> gnt sequence 0001, 0010, 0100, 1000, 0001, 0010, 0100, 1000.
- Idle: req=4'b0000 -> next cycle gnt=0, gnt_vld=0. Then req=4'b0100 -> gnt=4'b0100, gnt_idx=2.
- Skip and wrap: with ptr=3 (after granting 2), req=4'b0011 -> gnt=4'b0001. Then req=4'b0011 again -> gnt=4'b0010.
- Single requester: req=4'b1000 held for 3 cycles -> gnt=4'b1000 on each cycle, gnt_idx=3.
- Random stress: 1000 cycles of $urandom_range(0,15) on req, with a random mid-run rst pulse. Checks:
  - Assertion $onehot0(gnt) never fires.
  - gnt is a subset of the previous cycle's req.
  - gnt_vld equals |gnt.
  - Outputs are 0 during reset.

Source files
------------

// File: rtl/arbiter_pkg.sv
// Shared constants and bit-vector helpers for the round-robin arbiter.
// Helpers work on a fixed 32-bit container; the live width is passed as an argument.
// Bits at or above the live width are always returned as zero.
package arbiter_pkg;

  localparam int unsigned DEFAULT_NUM_REQ = 4;
  localparam int unsigned MAX_REQ         = 32;
  localparam int unsigned MAX_IDX_W       = 5;

  typedef logic [MAX_REQ-1:0]   req_vec_t;
  typedef logic [MAX_IDX_W-1:0] idx_t;
  typedef logic [MAX_IDX_W:0]   cnt_t;

  // Rotate the low n bits of v right by sh (sh < n): result[i] = v[(i+sh) mod n].
  function automatic req_vec_t rotr(input req_vec_t v, input idx_t sh, input cnt_t n);
    req_vec_t r;
    cnt_t     s;
    r = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      s = cnt_t'(i) + {1'b0, sh};
      if (s >= n) s = s - n;
      if (cnt_t'(i) < n) r[i] = v[s[MAX_IDX_W-1:0]];
    end
    return r;
  endfunction

  // Rotate the low n bits of v left by sh (sh < n): result[i] = v[(i-sh) mod n].
  function automatic req_vec_t rotl(input req_vec_t v, input idx_t sh, input cnt_t n);
    req_vec_t r;
    cnt_t     s;
    r = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      s = cnt_t'(i) + n - {1'b0, sh};
      if (s >= n) s = s - n;
      if (cnt_t'(i) < n) r[i] = v[s[MAX_IDX_W-1:0]];
    end
    return r;
  endfunction

  // Keep only the lowest set bit (fixed priority, bit 0 highest).
  function automatic req_vec_t lowest_set(input req_vec_t v);
    return v & (~v + req_vec_t'(1));
  endfunction

  // Binary index of a one-hot vector; zero for an all-zero vector.
  function automatic idx_t onehot_to_idx(input req_vec_t oh);
    idx_t idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = idx | idx_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/arbiter_rr_picker.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
// Latency: zero (pure logic); the caller registers the result.
// Backpressure: none; a pick is produced every evaluation, all-zero when idle.
module rr_picker
  import arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEFAULT_NUM_REQ,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               vld_o
);

  localparam cnt_t N = cnt_t'(NUM_REQ);

  req_vec_t req_ext;
  req_vec_t req_rot;
  req_vec_t pick_rot;
  req_vec_t pick;
  idx_t     pick_idx;
  logic     unused_bits;

  // Rotate so ptr lands on bit 0, take the lowest request, rotate back.
  always_comb begin
    req_ext                = '0;
    req_ext[NUM_REQ-1:0]   = req_i;
    req_rot                = rotr(req_ext, idx_t'(ptr_i), N);
    pick_rot               = lowest_set(req_rot);
    pick                   = rotl(pick_rot, idx_t'(ptr_i), N);
    pick_idx               = onehot_to_idx(pick);
  end

  assign gnt_o = pick[NUM_REQ-1:0];
  assign idx_o = pick_idx[IDX_W-1:0];
  assign vld_o = |pick[NUM_REQ-1:0];

  // Upper container bits are zero by construction.
  assign unused_bits = ^{pick, pick_idx};

endmodule

// File: rtl/arbiter.sv
// Registered round-robin arbiter: one-hot grant to the first requester at/after ptr.
// Latency: one cycle from req sample to gnt/gnt_vld/gnt_idx; all outputs are flops.
// Backpressure: none; arbitration re-runs every cycle, grants are never held.
module arbiter
  import arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEFAULT_NUM_REQ,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_vld,
  output logic [IDX_W-1:0]   gnt_idx
);

  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               vld_q, vld_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (gnt_d),
    .idx_o (idx_d),
    .vld_o (vld_d)
  );

  // Advance priority just past the winner; hold it when nobody asked.
  always_comb begin
    ptr_d = ptr_q;
    if (vld_d) begin
      if (idx_d == IDX_W'(NUM_REQ - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = idx_d + IDX_W'(1);
      end
    end
  end

  // Grant and pointer registers; reset clears outputs without waiting for a clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt_q <= '0;
      vld_q <= 1'b0;
      idx_q <= '0;
      ptr_q <= '0;
    end else begin
      gnt_q <= gnt_d;
      vld_q <= vld_d;
      idx_q <= idx_d;
      ptr_q <= ptr_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_vld = vld_q;
  assign gnt_idx = idx_q;

endmodule

// File: tb/tb_arbiter.sv
// Directed and randomized checks of the 4-requester round-robin arbiter.
module tb_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       gnt_vld;
  logic [1:0] gnt_idx;

  int vectors;
  int miscompares;

  // Reference state for the randomized section.
  int         mptr;
  logic [3:0] eg;
  int         eidx;

  arbiter #(.NUM_REQ(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .gnt     (gnt),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] g, input int idx);
    chk({tag, ".gnt"},     32'(gnt),     32'(g));
    chk({tag, ".gnt_vld"}, 32'(gnt_vld), 32'(|g));
    chk({tag, ".gnt_idx"}, 32'(gnt_idx), 32'(idx));
  endtask

  // Apply req at a falling edge; outputs are sampled at the next falling edge.
  task automatic cyc(input logic [3:0] r);
    req = r;
    @(negedge clk);
  endtask

  // Independent round-robin reference: scan from mptr upward, wrap at 4.
  task automatic predict(input logic [3:0] r);
    int b;
    eg   = 4'b0000;
    eidx = 0;
    for (int k = 0; k < 4; k++) begin
      b = (mptr + k) % 4;
      if (r[b] && eg == 4'b0000) begin
        eg   = 4'b0001 << b;
        eidx = b;
      end
    end
    if (eg != 4'b0000) mptr = (eidx + 1) % 4;
  endtask

  initial begin
    logic [3:0] full_seq [8];
    logic [3:0] r;
    int         rst_at;
    logic       rst_now;

    vectors     = 0;
    miscompares = 0;
    full_seq    = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                    4'b0001, 4'b0010, 4'b0100, 4'b1000};

    // Reset held with all requesters active: outputs stay zero.
    rst = 1'b0;
    req = 4'b1111;
    @(negedge clk);
    chk_out("reset_c0", 4'b0000, 0);
    @(negedge clk);
    chk_out("reset_c1", 4'b0000, 0);

    // Full load rotation starting from requester 0.
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc(4'b1111);
      chk_out($sformatf("rotate_%0d", i), full_seq[i], i % 4);
    end

    // Idle, then a single request at 2.
    cyc(4'b0000);
    chk_out("idle", 4'b0000, 0);
    cyc(4'b0100);
    chk_out("after_idle", 4'b0100, 2);

    // ptr=3: skip 3, wrap to 0, then advance to 1.
    cyc(4'b0011);
    chk_out("skip_wrap0", 4'b0001, 0);
    cyc(4'b0011);
    chk_out("skip_wrap1", 4'b0010, 1);

    // Lone continuous requester granted every cycle.
    for (int i = 0; i < 3; i++) begin
      cyc(4'b1000);
      chk_out($sformatf("single_%0d", i), 4'b1000, 3);
    end

    // Wrap-around from the top requester back to 0.
    cyc(4'b0100);
    chk_out("wrap_pre", 4'b0100, 2);
    cyc(4'b1001);
    chk_out("wrap_top", 4'b1000, 3);
    cyc(4'b1001);
    chk_out("wrap_zero", 4'b0001, 0);

    // Granted requester 1 drops its request: its grant drops next edge.
    cyc(4'b1111);
    chk_out("drop_pre", 4'b0010, 1);
    cyc(4'b1101);
    chk_out("drop_post", 4'b0100, 2);

    // Asynchronous reset between clock edges clears outputs immediately.
    #2 rst = 1'b0;
    #1;
    chk_out("async_rst_now", 4'b0000, 0);
    @(negedge clk);
    chk_out("async_rst_held", 4'b0000, 0);
    rst = 1'b1;
    cyc(4'b1111);
    chk_out("async_rst_release", 4'b0001, 0);

    // Randomized stress with a mid-run reset pulse.
    mptr   = 1;
    rst_at = $urandom_range(300, 700);
    for (int c = 0; c < 1000; c++) begin
      r       = 4'($urandom_range(0, 15));
      rst_now = !(c >= rst_at && c < rst_at + 2);
      if (!rst_now) begin
        eg   = 4'b0000;
        eidx = 0;
        mptr = 0;
      end else begin
        predict(r);
      end
      rst = rst_now;
      cyc(r);
      chk("stress.onehot0", 32'($onehot0(gnt)), 32'd1);
      chk("stress.subset",  32'(gnt & ~r),      32'd0);
      chk("stress.vld",     32'(gnt_vld),       32'(|gnt));
      chk("stress.gnt",     32'(gnt),           32'(eg));
      chk("stress.idx",     32'(gnt_idx),       32'(eidx));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
